// File: rtl/shacc_pkg.sv
// ============================================================================
// shacc_pkg : shared widths and state encoding for the sequential multiplier
// Revision  : 1.0
// ============================================================================
`default_nettype none

package shacc_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mult_state_t;

endpackage

`default_nettype wire

// File: rtl/shacc_seq_mult_stage.sv
// ============================================================================
// shacc : combinational shift-add stage (one multiplication iteration)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module shacc
    import shacc_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] in_acc,
    input  logic [W-1:0] in_sh1,
    input  logic [W-1:0] in_sh2,
    output logic [W-1:0] out_acc,
    output logic [W-1:0] out_sh1,
    output logic [W-1:0] out_sh2
);

    // Adder wraps at W bits; bits shifted out of sh1 are simply lost.
    assign out_acc = in_sh2[0] ? (in_acc + in_sh1) : in_acc;
    assign out_sh1 = in_sh1 << 1;
    assign out_sh2 = in_sh2 >> 1;

endmodule

`default_nettype wire

// File: rtl/shacc_seq_mult.sv
// ============================================================================
// shacc_seq_mult : sequential 16x16 shift-add multiplier, low 16 product bits
// Revision       : 1.0
// ============================================================================
`default_nettype none

module shacc_seq_mult
    import shacc_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_product,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    mult_state_t       state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] sh1_q, sh1_d;
    logic [DATA_W-1:0] sh2_q, sh2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] stg_acc;
    logic [DATA_W-1:0] stg_sh1;
    logic [DATA_W-1:0] stg_sh2;

    shacc #(.W(DATA_W)) U_STAGE (
        .in_acc  (acc_q),
        .in_sh1  (sh1_q),
        .in_sh2  (sh2_q),
        .out_acc (stg_acc),
        .out_sh1 (stg_sh1),
        .out_sh2 (stg_sh2)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    acc_d   = '0;
                    sh1_d   = in_a;
                    sh2_d   = in_b;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = stg_acc;
                sh1_d = stg_sh1;
                sh2_d = stg_sh2;
                cnt_d = cnt_q + CNT_W'(1);
                // Once the multiplier is exhausted further iterations add nothing.
                if ((cnt_q == LAST_CNT) || (EARLY_EXIT && (stg_sh2 == '0))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign out_product = (state_q == S_DONE) ? acc_q : '0;

endmodule

`default_nettype wire
